// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM sequencer for data loads/stores and instruction fetches,
// one request at a time, finished with a one-cycle ready pulse.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        d_waiting,
    input  logic        d_wr,
    input  logic [2:0]  d_len,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_value,
    output logic        mem_rdy,
    output logic [31:0] mem_result,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_rdy,
    output logic [31:0] if_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t      state;
    logic [31:0] base, wdata, rbuf;
    logic [2:0]  n, cnt;
    logic [1:0]  rd_idx;
    logic        sgn, is_if, io_stall;
    assign io_stall = base[17:16] == 2'b11 && io_buffer_full;
    // READ captures the byte for the address driven one cycle earlier
    assign rd_idx = cnt[1:0] - 2'd1;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            base  <= '0;
            wdata <= '0;
            rbuf  <= '0;
            n     <= '0;
            cnt   <= '0;
            sgn   <= 1'b0;
            is_if <= 1'b0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    rbuf <= '0;
                    if (d_waiting) begin
                        base  <= d_addr;
                        wdata <= d_value;
                        n     <= d_len[1:0] == 2'd0 ? 3'd1 : d_len[1:0] == 2'd1 ? 3'd2 : 3'd4;
                        sgn   <= d_len[2];
                        is_if <= 1'b0;
                        state <= d_wr ? WRITE : READ;
                    end else if (if_valid) begin
                        base  <= if_addr;
                        n     <= 3'd4;
                        sgn   <= 1'b0;
                        is_if <= 1'b1;
                        state <= READ;
                    end
                end
                READ: begin
                    if (is_if && if_flush) state <= IDLE;
                    else begin
                        if (cnt != 3'd0) rbuf[{rd_idx, 3'b000} +: 8] <= mem_din;
                        cnt <= cnt + 3'd1;
                        if (cnt == n) state <= DONE;
                    end
                end
                WRITE: begin
                    if (!io_stall) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == n - 3'd1) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign mem_a      = (state == READ || state == WRITE) ? base + {29'd0, cnt} : 32'd0;
    assign mem_wr     = state == WRITE && rdy_in && !io_stall;
    assign mem_dout   = state == WRITE ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'd0;
    assign mem_rdy    = state == DONE && !is_if;
    assign if_rdy     = state == DONE && is_if && !if_flush;
    assign if_data    = rbuf;
    assign mem_result = !sgn ? rbuf :
                        n == 3'd1 ? {{24{rbuf[7]}}, rbuf[7:0]} :
                        n == 3'd2 ? {{16{rbuf[15]}}, rbuf[15:0]} : rbuf;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a RAM model and a
// byte-level reference memory.
module tb_mem_ctrl;
    logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
    logic        d_waiting = 1'b0, d_wr = 1'b0;
    logic [2:0]  d_len = '0;
    logic [31:0] d_addr = '0, d_value = '0;
    logic        mem_rdy, if_rdy, mem_wr;
    logic [31:0] mem_result, if_data, mem_a;
    logic        if_valid = 1'b0, if_flush = 1'b0, io_buffer_full = 1'b0;
    logic [31:0] if_addr = '0;
    logic [7:0]  mem_din = '0, mem_dout;
    int          total = 0, bad = 0;
    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .d_waiting(d_waiting), .d_wr(d_wr), .d_len(d_len), .d_addr(d_addr), .d_value(d_value),
        .mem_rdy(mem_rdy), .mem_result(mem_result),
        .if_valid(if_valid), .if_addr(if_addr), .if_flush(if_flush), .if_rdy(if_rdy), .if_data(if_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // RAM: one-cycle read latency, pauses together with the controller
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) ram[mem_a] = mem_dout;
            mem_din <= ram_rd(mem_a);
        end
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic data_txn(input logic wr, input logic [2:0] len, input logic [31:0] addr,
                            input logic [31:0] val, input bit timed);
        int n, cyc;
        logic [31:0] exp, m;
        bit got;
        n = len[1:0] == 2'd0 ? 1 : len[1:0] == 2'd1 ? 2 : 4;
        exp = 0;
        if (!wr) begin
            for (int k = 0; k < n; k++) exp |= 32'(ref_rd(addr + k)) << (8 * k);
            m = (n == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * n)) - 32'd1;
            if (len[2] && n < 4 && exp[8 * n - 1]) exp |= ~m;
        end
        d_waiting = 1'b1; d_wr = wr; d_len = len; d_addr = addr; d_value = val;
        cyc = 0; got = 0;
        while (!got && cyc < 100) begin
            tick; cyc++;
            if (timed && cyc <= n) begin
                check("addr", mem_a, addr + cyc - 1);
                check("wr", 32'(mem_wr), 32'(wr));
                if (wr) check("dout", 32'(mem_dout), (val >> (8 * (cyc - 1))) & 32'hFF);
            end
            got = mem_rdy;
            if (!timed) rdy_in = $urandom_range(0, 3) != 0;
        end
        rdy_in = 1'b1;
        check("done", 32'(got), 1);
        if (timed) check("latency", cyc, wr ? n + 1 : n + 2);
        check("result", mem_result, exp);
        if (wr) for (int k = 0; k < n; k++) ref_mem[addr + k] = 8'(val >> (8 * k));
        d_waiting = 1'b0;
        tick;
        check("pulse", 32'(mem_rdy), 0);
    endtask

    task automatic fetch_txn(input logic [31:0] addr, input bit timed);
        int cyc;
        logic [31:0] exp;
        bit got;
        exp = 0;
        for (int k = 0; k < 4; k++) exp |= 32'(ref_rd(addr + k)) << (8 * k);
        if_valid = 1'b1; if_addr = addr;
        cyc = 0; got = 0;
        while (!got && cyc < 100) begin
            tick; cyc++;
            if (timed && cyc <= 4) check("if_addr", mem_a, addr + cyc - 1);
            got = if_rdy;
            if (!timed) rdy_in = $urandom_range(0, 3) != 0;
        end
        rdy_in = 1'b1;
        check("if_done", 32'(got), 1);
        if (timed) check("if_latency", cyc, 6);
        check("if_data", if_data, exp);
        if_valid = 1'b0;
        tick;
        check("if_pulse", 32'(if_rdy), 0);
    endtask

    initial begin
        logic [31:0] a;
        #1;
        check("rst_a", mem_a, 0);
        check("rst_wr", 32'(mem_wr), 0);
        check("rst_dout", 32'(mem_dout), 0);
        check("rst_rdy", 32'(mem_rdy), 0);
        check("rst_if_rdy", 32'(if_rdy), 0);
        check("rst_result", mem_result, 0);
        check("rst_if_data", if_data, 0);
        repeat (2) tick;
        rst_in = 1'b1;
        tick;
        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        preload(32'h200, 8'h80);
        preload(32'h210, 8'h01); preload(32'h211, 8'h80);
        data_txn(1'b0, 3'b010, 32'h100, 0, 1);
        check("lw_value", ref_rd(32'h103), 8'h44);
        data_txn(1'b0, 3'b100, 32'h200, 0, 1);
        data_txn(1'b0, 3'b000, 32'h200, 0, 1);
        data_txn(1'b0, 3'b101, 32'h210, 0, 1);
        data_txn(1'b0, 3'b001, 32'h210, 0, 1);
        data_txn(1'b0, 3'b011, 32'h100, 0, 1);
        data_txn(1'b0, 3'b111, 32'hFFFFFFFE, 0, 1);
        data_txn(1'b1, 3'b001, 32'h300, 32'hABCD1234, 1);
        data_txn(1'b1, 3'b010, 32'h310, 32'hCAFEF00D, 1);
        data_txn(1'b0, 3'b110, 32'h310, 0, 1);
        data_txn(1'b0, 3'b100, 32'h200, 0, 1);
        data_txn(1'b0, 3'b100, 32'h201, 0, 1);
        // data and fetch requests arriving together
        if_valid = 1'b1; if_addr = 32'h500;
        data_txn(1'b0, 3'b010, 32'h600, 0, 1);
        fetch_txn(32'h500, 1);
        // fetch aborted by a flush, then a fresh fetch
        if_valid = 1'b1; if_addr = 32'h700;
        tick;
        check("fl_addr", mem_a, 32'h700);
        tick;
        if_flush = 1'b1; if_addr = 32'h800;
        tick;
        check("fl_idle", mem_a, 0);
        check("fl_no_rdy", 32'(if_rdy), 0);
        if_flush = 1'b0;
        fetch_txn(32'h800, 1);
        // IO store held off by a full UART buffer
        d_waiting = 1'b1; d_wr = 1'b1; d_len = 3'b000; d_addr = 32'h30000; d_value = 32'h000000C3;
        io_buffer_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("io_hold", 32'(mem_wr), 0);
        end
        tick;
        io_buffer_full = 1'b0;
        #1;
        check("io_wr", 32'(mem_wr), 1);
        check("io_a", mem_a, 32'h30000);
        check("io_dout", 32'(mem_dout), 32'hC3);
        tick;
        check("io_rdy", 32'(mem_rdy), 1);
        ref_mem[32'h30000] = 8'hC3;
        d_waiting = 1'b0;
        tick;
        // reset in the middle of a store
        d_waiting = 1'b1; d_wr = 1'b1; d_len = 3'b010; d_addr = 32'h900; d_value = 32'hDEADBEEF;
        tick;
        tick;
        check("mid_wr", 32'(mem_wr), 1);
        rst_in = 1'b0;
        #1;
        check("mrst_wr", 32'(mem_wr), 0);
        check("mrst_a", mem_a, 0);
        check("mrst_dout", 32'(mem_dout), 0);
        check("mrst_rdy", 32'(mem_rdy), 0);
        check("mrst_if_rdy", 32'(if_rdy), 0);
        check("mrst_result", mem_result, 0);
        ref_mem[32'h900] = 8'hEF;
        d_waiting = 1'b0;
        tick;
        rst_in = 1'b1;
        tick;
        // randomized traffic with random pauses
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFD + $urandom_range(0, 2) : 32'h400 + $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) fetch_txn(a, 0);
            else data_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 0);
        end
        foreach (ram[k]) check("mem", 32'(ram[k]), 32'(ref_rd(k)));
        foreach (ref_mem[k]) check("mem_ref", 32'(ram_rd(k)), 32'(ref_mem[k]));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
